fpu_sub_ctrl: RTL and testbench
===============================

FPU_SUB_CTRL -- requirements
Module: fpu_sub_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 13: the number of enabled clock edges the subtract pipeline needs before its outputs reflect held operands (legal range 1..63).
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 2: per-requester request valid.
REQ-005 SHALL have port req_ready, output, 2: per-requester grant/accept strobe.
REQ-006 SHALL have ports req0_opa and req0_opb, input, 64 each: requester 0 operands (IEEE double).
REQ-007 SHALL have ports req1_opa and req1_opb, input, 64 each: requester 1 operands.
REQ-008 SHALL have ports req0_op and req1_op, input, 3 each: fpu_op per requester (3'b000 add, 3'b001 sub).
REQ-009 SHALL have ports sub_enable (output, 1), sub_opa and sub_opb (output, 64 each), and sub_fpu_op (output, 3): drive to the subtract pipeline.
REQ-010 SHALL have ports sub_sign (input, 1), sub_diff_2 (input, 56), sub_exponent_2 (input, 11) and sub_shift_inexact (input, 1): subtract pipeline results.
REQ-011 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_id (output, 1), rsp_sign (output, 1), rsp_diff (output, 56), rsp_exponent (output, 11) and rsp_inexact (output, 1).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, CAPT and RESP; one operation is in flight at a time.
REQ-013 In IDLE with any req_valid bit set, SHALL assert req_ready for exactly one granted requester for one cycle, latch its operands, op and id, reset the counter to 0, and enter RUN.
REQ-014 In IDLE with req_valid==0, SHALL hold all outputs steady with sub_enable=0.
REQ-015 In RUN, SHALL assert sub_enable=1, drive the latched operands and op unchanged every cycle, and increment a 6-bit counter.
REQ-016 In RUN, when the counter equals LATENCY-1, SHALL enter CAPT on the next edge, giving exactly LATENCY enabled cycles.
REQ-017 In CAPT, SHALL drive sub_enable=0, latch sub_sign, sub_diff_2, sub_exponent_2 and sub_shift_inexact into the rsp_* registers, and enter RESP.
REQ-018 In RESP, SHALL hold rsp_valid=1 and all rsp_* values stable until rsp_ready=1, then return to IDLE on that edge.
REQ-019 Latency SHALL be LATENCY+2 cycles from the req_ready cycle to the first rsp_valid cycle; the minimum issue interval is LATENCY+3 cycles.
REQ-020 req_ready SHALL be 0 in RUN, CAPT and RESP regardless of req_valid; requesters hold req_valid and operands until accepted.
REQ-021 sub_opa, sub_opb and sub_fpu_op SHALL retain the last latched values outside RUN, so the pipeline is never presented with changing operands mid-operation.
REQ-022 rsp_valid with rsp_ready already high in the CAPT cycle SHALL still produce one RESP cycle (no combinational bypass).

Reset
REQ-023 rst=1 at any edge SHALL force IDLE, counter=0, req_ready=0, sub_enable=0, sub_opa=0, sub_opb=0, sub_fpu_op=0, rsp_valid=0, rsp_id=0, rsp_sign=0, rsp_diff=0, rsp_exponent=0, rsp_inexact=0, and round-robin pointer=0.
REQ-024 rst mid-RUN or mid-RESP SHALL discard the in-flight operation with no response emitted; the first grant after reset follows REQ-013.

Configuration
REQ-025 With macro FPU_SUB_CTRL_RR_ARB_EN defined, grant SHALL be round-robin: the pointer names the preferred requester; after each grant the pointer moves to the other requester.
REQ-026 Without FPU_SUB_CTRL_RR_ARB_EN, grant SHALL be fixed priority, with requester 0 winning whenever both are valid, and no pointer state exists.

Verification
REQ-027 Single request: req0 opa=0x4008000000000000 (3.0), opb=0x3FF0000000000000 (1.0), op=001, LATENCY=13 -> rsp_valid at grant+15, rsp_id=0, rsp_sign=0, rsp_exponent=0x400, rsp_inexact=0.
REQ-028 Both valid every cycle, 4 operations -> RR build grants 0,1,0,1; fixed-priority build grants 0,0,0,0 with requester 1 starved.
REQ-029 rsp_ready held low for 10 cycles after rsp_valid -> rsp_* stable, req_ready stays 0, and no new grant until the handshake.
REQ-030 rst pulsed in the 5th RUN cycle -> sub_enable=0 and IDLE next cycle, no rsp_valid, and a pending req1 is granted in the cycle after rst deasserts.
REQ-031 During RUN, toggle req0_opa every cycle -> sub_opa constant at the latched value for all LATENCY cycles.

Source files
------------

// File: rtl/fpu_sub_ctrl.sv
// fpu_sub_ctrl: sequences one double-precision add/sub operation at a time
// through a multi-cycle subtract pipeline on behalf of two requesters.
//
// Compile-time option:
//   FPU_SUB_CTRL_RR_ARB_EN  defined   -> round-robin arbitration between requesters
//                           undefined -> fixed priority, requester 0 wins
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; req_ready strobes the winner this cycle
// RUN   | pipeline enabled with latched operands for LATENCY cycles
// CAPT  | pipeline disabled, its results are copied into the rsp_* regs
// RESP  | rsp_valid held until rsp_ready completes the handshake
//
// Timing (grant cycle = cycle 0):
//   cycles 1..LATENCY    RUN, sub_enable=1
//   cycle  LATENCY+1     CAPT
//   cycle  LATENCY+2     RESP, first rsp_valid cycle
// With rsp_ready high the next grant can land at cycle LATENCY+3.

module fpu_sub_ctrl #(
  // Enabled pipeline edges per operation; legal range 1..63.
  parameter int unsigned LATENCY = 13
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req0_opa,
  input  logic [63:0] req0_opb,
  input  logic [63:0] req1_opa,
  input  logic [63:0] req1_opb,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,

  output logic        sub_enable,
  output logic [63:0] sub_opa,
  output logic [63:0] sub_opb,
  output logic [2:0]  sub_fpu_op,
  input  logic        sub_sign,
  input  logic [55:0] sub_diff_2,
  input  logic [10:0] sub_exponent_2,
  input  logic        sub_shift_inexact,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic        rsp_sign,
  output logic [55:0] rsp_diff,
  output logic [10:0] rsp_exponent,
  output logic        rsp_inexact
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [5:0] CNT_LAST = 6'(LATENCY - 1);

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic        id_q;

  logic        sub_enable_q;
  logic [63:0] sub_opa_q;
  logic [63:0] sub_opb_q;
  logic [2:0]  sub_fpu_op_q;

  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic        rsp_sign_q;
  logic [55:0] rsp_diff_q;
  logic [10:0] rsp_exponent_q;
  logic        rsp_inexact_q;

  logic [1:0]  grant_d;
  logic        grant_id;
  logic        accept;

`ifdef FPU_SUB_CTRL_RR_ARB_EN
  // Preferred requester when both are valid; flips to the loser after each grant.
  logic rr_ptr_q;

  // Round-robin pick: the pointer breaks ties, a lone requester always wins.
  always_comb begin
    grant_d = 2'b00;
    if (req_valid == 2'b11) begin
      grant_d = rr_ptr_q ? 2'b10 : 2'b01;
    end else begin
      grant_d = req_valid;
    end
  end

  // Move the pointer away from whichever requester was just accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else if (accept) begin
      rr_ptr_q <= ~grant_id;
    end
  end
`else
  // Fixed priority pick: requester 0 wins whenever it is valid.
  always_comb begin
    grant_d = 2'b00;
    if (req_valid[0]) begin
      grant_d = 2'b01;
    end else if (req_valid[1]) begin
      grant_d = 2'b10;
    end
  end
`endif

  assign grant_id = grant_d[1];

  // The accept strobe is decoded from the registered state so the grant
  // lands in the IDLE cycle itself; reset blanks it while rst is high.
  assign req_ready = (state_q == IDLE && !rst) ? grant_d : 2'b00;
  assign accept    = |req_ready;

  // Main controller: state, run counter and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 6'd0;
      id_q           <= 1'b0;
      sub_enable_q   <= 1'b0;
      sub_opa_q      <= 64'd0;
      sub_opb_q      <= 64'd0;
      sub_fpu_op_q   <= 3'd0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_sign_q     <= 1'b0;
      rsp_diff_q     <= 56'd0;
      rsp_exponent_q <= 11'd0;
      rsp_inexact_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sub_opa_q    <= grant_id ? req1_opa : req0_opa;
            sub_opb_q    <= grant_id ? req1_opb : req0_opb;
            sub_fpu_op_q <= grant_id ? req1_op  : req0_op;
            id_q         <= grant_id;
            cnt_q        <= 6'd0;
            sub_enable_q <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          // Operands stay frozen; only the counter moves.
          if (cnt_q == CNT_LAST) begin
            sub_enable_q <= 1'b0;
            state_q      <= CAPT;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        CAPT: begin
          rsp_id_q       <= id_q;
          rsp_sign_q     <= sub_sign;
          rsp_diff_q     <= sub_diff_2;
          rsp_exponent_q <= sub_exponent_2;
          rsp_inexact_q  <= sub_shift_inexact;
          rsp_valid_q    <= 1'b1;
          state_q        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sub_enable   = sub_enable_q;
  assign sub_opa      = sub_opa_q;
  assign sub_opb      = sub_opb_q;
  assign sub_fpu_op   = sub_fpu_op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_sign     = rsp_sign_q;
  assign rsp_diff     = rsp_diff_q;
  assign rsp_exponent = rsp_exponent_q;
  assign rsp_inexact  = rsp_inexact_q;

endmodule

// File: tb/tb_fpu_sub_ctrl.sv
// Directed bench for fpu_sub_ctrl with a toy stall-able pipeline model that
// only advances on enabled edges, so results are correct only after exactly
// LAT enabled cycles with stable operands.
module tb_fpu_sub_ctrl;

  localparam int LAT = 13;

  typedef struct packed {
    logic        s;
    logic [55:0] d;
    logic [10:0] e;
    logic        x;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req0_opa, req0_opb, req1_opa, req1_opb;
  logic [2:0]  req0_op, req1_op;
  logic        sub_enable;
  logic [63:0] sub_opa, sub_opb;
  logic [2:0]  sub_fpu_op;
  logic        sub_sign;
  logic [55:0] sub_diff_2;
  logic [10:0] sub_exponent_2;
  logic        sub_shift_inexact;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_sign, rsp_inexact;
  logic [55:0] rsp_diff;
  logic [10:0] rsp_exponent;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int en_cnt = 0;

  res_t pipe [LAT];

  always #5 clk = ~clk;

  fpu_sub_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_opa(req0_opa), .req0_opb(req0_opb),
    .req1_opa(req1_opa), .req1_opb(req1_opb),
    .req0_op(req0_op), .req1_op(req1_op),
    .sub_enable(sub_enable), .sub_opa(sub_opa), .sub_opb(sub_opb),
    .sub_fpu_op(sub_fpu_op),
    .sub_sign(sub_sign), .sub_diff_2(sub_diff_2),
    .sub_exponent_2(sub_exponent_2), .sub_shift_inexact(sub_shift_inexact),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sign(rsp_sign), .rsp_diff(rsp_diff), .rsp_exponent(rsp_exponent),
    .rsp_inexact(rsp_inexact)
  );

  function automatic res_t fmodel(input logic [63:0] a, input logic [63:0] b,
                                  input logic [2:0] op);
    res_t r;
    r.s = a[63];
    r.d = a[55:0] ^ b[55:0];
    r.e = a[62:52];
    r.x = b[0] ^ op[1];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '1;
    end else if (sub_enable) begin
      pipe[0] <= fmodel(sub_opa, sub_opb, sub_fpu_op);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign sub_sign          = pipe[LAT-1].s;
  assign sub_diff_2        = pipe[LAT-1].d;
  assign sub_exponent_2    = pipe[LAT-1].e;
  assign sub_shift_inexact = pipe[LAT-1].x;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sub_enable) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   bad;
    int   e0;
    int   n;
    int   g_cyc [4];
    logic [1:0] exp_g;

    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
    req0_opa = 64'h1234; req0_opb = 64'h5678; req0_op = 3'b001;
    req1_opa = 64'h9abc; req1_opb = 64'hdef0; req1_op = 3'b001;
    repeat (3) @(negedge clk);

    chk("rst_req_ready",  64'(req_ready), 64'(0));
    chk("rst_sub_enable", 64'(sub_enable), 64'(0));
    chk("rst_sub_opa",    sub_opa, 64'(0));
    chk("rst_sub_opb",    sub_opb, 64'(0));
    chk("rst_sub_op",     64'(sub_fpu_op), 64'(0));
    chk("rst_rsp_valid",  64'(rsp_valid), 64'(0));
    chk("rst_rsp_diff",   64'(rsp_diff), 64'(0));
    chk("rst_rsp_misc",   64'({rsp_id, rsp_sign, rsp_exponent, rsp_inexact}), 64'(0));

    rst = 1'b0; req_valid = 2'b00;
    @(negedge clk);
    chk("idle_sub_enable", 64'(sub_enable), 64'(0));
    chk("idle_req_ready",  64'(req_ready), 64'(0));

    // Single request 3.0 - 1.0 from requester 0, operand toggled during RUN.
    req0_opa = 64'h4008_0000_0000_0000;
    req0_opb = 64'h3FF0_0000_0000_0000;
    req0_op  = 3'b001;
    req_valid = 2'b01;
    #1;
    chk("t1_grant", 64'(req_ready), 64'(2'b01));
    e0 = en_cnt; lat = 0; bad = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) req_valid = 2'b00;
      if (sub_enable && sub_opa !== 64'h4008_0000_0000_0000) bad++;
      if (sub_enable && sub_fpu_op !== 3'b001) bad++;
      req0_opa = ~req0_opa;
    end
    chk("t1_latency",    64'(lat), 64'(15));
    chk("t1_en_cycles",  64'(en_cnt - e0), 64'(LAT));
    chk("t1_opa_stable", 64'(bad), 64'(0));
    chk("t1_rsp_id",     64'(rsp_id), 64'(0));
    chk("t1_rsp_sign",   64'(rsp_sign), 64'(0));
    chk("t1_rsp_exp",    64'(rsp_exponent), 64'(11'h400));
    chk("t1_rsp_inex",   64'(rsp_inexact), 64'(0));
    chk("t1_rsp_diff",   64'(rsp_diff), 64'(56'hF8_0000_0000_0000));

    // Back-pressure for 10 cycles while requester 1 waits.
    req1_opa = 64'hC000_0000_0000_0000;
    req1_opb = 64'h3FF0_0000_0000_0001;
    req1_op  = 3'b000;
    req_valid = 2'b10;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_sign !== 1'b0) bad++;
      if (rsp_exponent !== 11'h400 || rsp_diff !== 56'hF8_0000_0000_0000) bad++;
      if (req_ready !== 2'b00 || sub_enable !== 1'b0) bad++;
    end
    chk("t2_hold_stable", 64'(bad), 64'(0));
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t2_released",   64'(rsp_valid), 64'(0));
    chk("t2_grant_req1", 64'(req_ready), 64'(2'b10));

    // Requester 1 with rsp_ready already high through CAPT.
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) req_valid = 2'b00;
    end
    chk("t2_latency",  64'(lat), 64'(15));
    chk("t2_rsp_id",   64'(rsp_id), 64'(1));
    chk("t2_rsp_sign", 64'(rsp_sign), 64'(1));
    chk("t2_rsp_exp",  64'(rsp_exponent), 64'(11'h400));
    chk("t2_rsp_inex", 64'(rsp_inexact), 64'(1));
    chk("t2_rsp_diff", 64'(rsp_diff), 64'(56'hF0_0000_0000_0001));
    @(negedge clk);
    chk("t2_one_resp_cycle", 64'(rsp_valid), 64'(0));

    // Both requesters valid continuously: four grants at minimum interval.
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 40) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("t3_grant_seen", 64'(n < 40), 64'(1));
`ifdef FPU_SUB_CTRL_RR_ARB_EN
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      chk("t3_grant", 64'(req_ready), 64'(exp_g));
      g_cyc[k] = cyc;
      if (k > 0) chk("t3_interval", 64'(g_cyc[k] - g_cyc[k-1]), 64'(LAT + 3));
      @(negedge clk);
      #1;
    end

    // Reset in the 5th RUN cycle of the last operation; requester 1 pending.
    req_valid = 2'b10;
    repeat (4) @(negedge clk);
    chk("t4_in_run", 64'(sub_enable), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_sub_enable", 64'(sub_enable), 64'(0));
    chk("t4_rst_rsp_valid",  64'(rsp_valid), 64'(0));
    chk("t4_rst_req_ready",  64'(req_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("t4_grant_after_rst", 64'(req_ready), 64'(2'b10));
    e0 = en_cnt; lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) req_valid = 2'b00;
    end
    chk("t4_latency",   64'(lat), 64'(15));
    chk("t4_en_cycles", 64'(en_cnt - e0), 64'(LAT));
    chk("t4_rsp_id",    64'(rsp_id), 64'(1));
    chk("t4_rsp_exp",   64'(rsp_exponent), 64'(11'h400));
    chk("t4_rsp_diff",  64'(rsp_diff), 64'(56'hF0_0000_0000_0001));

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
